// File: rtl/memoria_parametrizada.sv
// Single-port synchronous scratch RAM with a registered read port, a valid strobe,
// a hardware clear sweep after reset or on request, and out-of-range address detection.
module memoria_parametrizada #(
  parameter  int ANCHO       = 8,
  parameter  int PROFUNDIDAD = 16,
  localparam int AW          = $clog2(PROFUNDIDAD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wre,
  input  logic             rde,
  input  logic             clr,
  input  logic [ANCHO-1:0] DEentrada,
  input  logic [AW-1:0]    Direccion,
  output logic [ANCHO-1:0] DSalida,
  output logic             valido,
  output logic             ocupado,
  output logic             err_dir
);

  typedef enum logic {
    BORRADO   = 1'b0,
    OPERACION = 1'b1
  } estado_t;

  localparam logic [AW-1:0] ULTIMA = AW'(PROFUNDIDAD - 1);
  localparam logic [AW:0]   LIMITE = (AW + 1)'(PROFUNDIDAD);

  logic [ANCHO-1:0] mem [PROFUNDIDAD];
  estado_t          estado;
  logic [AW-1:0]    cnt;

  logic             en_rango;
  logic             acceso;
  logic             mem_we;
  logic [AW-1:0]    mem_dir;
  logic [ANCHO-1:0] mem_dato;

  // Only reachable as false when the depth is not a power of two.
  assign en_rango = ({1'b0, Direccion} < LIMITE);
  assign ocupado  = (estado == BORRADO);
  assign acceso   = (estado == OPERACION) && !clr;

  // The sweep and the user write share the single array write port.
  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    mem_we   = 1'b0;
    mem_dir  = Direccion;
    mem_dato = DEentrada;
    if (ocupado) begin
      mem_we   = 1'b1;
      mem_dir  = cnt;
      mem_dato = '0;
    end else if (acceso && wre && en_rango) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the array has no reset on purpose; the post-reset sweep zeroes it instead,
  // which keeps it mappable onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_dir] <= mem_dato;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado  <= BORRADO;
      cnt     <= '0;
      DSalida <= '0;
      valido  <= 1'b0;
      err_dir <= 1'b0;
    end else begin
      case (estado)
        BORRADO: begin
          valido  <= 1'b0;
          err_dir <= 1'b0;
          if (clr) begin
            cnt <= '0;
          end else if (cnt == ULTIMA) begin
            estado <= OPERACION;
            cnt    <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        OPERACION: begin
          if (clr) begin
            estado  <= BORRADO;
            cnt     <= '0;
            valido  <= 1'b0;
            err_dir <= 1'b0;
          end else begin
            valido  <= rde;
            err_dir <= (wre || rde) && !en_rango;
            // Write-first on a same-address read/write; out-of-range reads return zero.
            if (rde) begin
              if (!en_rango)  DSalida <= '0;
              else if (wre)   DSalida <= DEentrada;
              else            DSalida <= mem[Direccion];
            end
          end
        end
        default: estado <= BORRADO;
      endcase
    end
  end

endmodule

// File: tb/tb_memoria_parametrizada.sv
// Bench for memoria_parametrizada: a 16-deep and a 12-deep instance checked against
// a word-level behavioural model (array contents plus remaining sweep length).
module tb_memoria_parametrizada;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wre_a, rde_a, clr_a, val_a, ocu_a, err_a;
  logic [7:0] din_a, dout_a;
  logic [3:0] dir_a;
  logic       wre_b, rde_b, clr_b, val_b, ocu_b, err_b;
  logic [7:0] din_b, dout_b;
  logic [3:0] dir_b;

  memoria_parametrizada #(.ANCHO(8), .PROFUNDIDAD(16)) dut_a (
    .clk(clk), .rst(rst), .wre(wre_a), .rde(rde_a), .clr(clr_a),
    .DEentrada(din_a), .Direccion(dir_a), .DSalida(dout_a),
    .valido(val_a), .ocupado(ocu_a), .err_dir(err_a)
  );

  memoria_parametrizada #(.ANCHO(8), .PROFUNDIDAD(12)) dut_b (
    .clk(clk), .rst(rst), .wre(wre_b), .rde(rde_b), .clr(clr_b),
    .DEentrada(din_b), .Direccion(dir_b), .DSalida(dout_b),
    .valido(val_b), .ocupado(ocu_b), .err_dir(err_b)
  );

  int errors = 0;
  int checks = 0;

  // Model: index 0 is the 16-deep instance, index 1 the 12-deep one.
  logic [7:0] m_mem  [2][16];
  int         m_left [2];
  logic [7:0] m_dout [2];
  logic       m_val  [2];
  logic       m_err  [2];

  function automatic int depth_of(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_left[d] = depth_of(d);
      m_dout[d] = 8'h00;
      m_val[d]  = 1'b0;
      m_err[d]  = 1'b0;
      for (int i = 0; i < 16; i++) m_mem[d][i] = 8'h00;
    end
  endtask

  task automatic model_edge(input int d, input logic w, input logic r, input logic c,
                            input logic [3:0] a, input logic [7:0] di);
    int   dep;
    logic inr;
    dep = depth_of(d);
    if (m_left[d] > 0) begin
      m_val[d] = 1'b0;
      m_err[d] = 1'b0;
      if (c) m_left[d] = dep;
      else   m_left[d] = m_left[d] - 1;
    end else if (c) begin
      m_left[d] = dep;
      m_val[d]  = 1'b0;
      m_err[d]  = 1'b0;
      for (int i = 0; i < 16; i++) m_mem[d][i] = 8'h00;
    end else begin
      inr = (int'(a) < dep);
      if (r) m_dout[d] = !inr ? 8'h00 : (w ? di : m_mem[d][a]);
      m_val[d] = r;
      m_err[d] = (w || r) && !inr;
      if (w && inr) m_mem[d][a] = di;
    end
  endtask

  task automatic idle_inputs();
    wre_a = 0; rde_a = 0; clr_a = 0; din_a = 8'h00; dir_a = 4'h0;
    wre_b = 0; rde_b = 0; clr_b = 0; din_b = 8'h00; dir_b = 4'h0;
  endtask

  task automatic tick();
    model_edge(0, wre_a, rde_a, clr_a, dir_a, din_a);
    model_edge(1, wre_b, rde_b, clr_b, dir_b, din_b);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({dout_a, val_a, ocu_a, err_a} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_a: got dout=%h val=%b ocu=%b err=%b want 00 0 1 0", dout_a, val_a, ocu_a, err_a);
    end
    checks++;
    if ({dout_b, val_b, ocu_b, err_b} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_b: got dout=%h val=%b ocu=%b err=%b want 00 0 1 0", dout_b, val_b, ocu_b, err_b);
    end
  endtask

  task automatic test_sweep_after_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wre_a = 1'b1; dir_a = 4'($urandom); din_a = 8'($urandom);
      tick();
      checks++;
      if (ocu_a !== logic'(i < 15) || val_a !== 1'b0) begin
        errors++;
        $display("FAIL sweep edge %0d: got ocu=%b val=%b want ocu=%b val=0", i, ocu_a, val_a, i < 15);
      end
    end
    wre_a = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rde_a = 1'b1; dir_a = 4'(a);
      tick();
      checks++;
      if ({dout_a, val_a, err_a} !== {8'h00, 1'b1, 1'b0} ||
          {dout_a, val_a, ocu_a, err_a} !== {m_dout[0], m_val[0], m_left[0] > 0, m_err[0]}) begin
        errors++;
        $display("FAIL swept_read @%0d: got dout=%h val=%b err=%b want 00 1 0", a, dout_a, val_a, err_a);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    logic [7:0] want_d [4];
    logic       want_v [4];
    want_d = '{8'hA5, 8'h3C, 8'h3C, 8'h3C};
    want_v = '{1'b1, 1'b1, 1'b0, 1'b0};
    wre_a = 1; dir_a = 4'd3;  din_a = 8'hA5; tick();
    wre_a = 1; dir_a = 4'd15; din_a = 8'h3C; tick();
    wre_a = 0;
    for (int i = 0; i < 4; i++) begin
      rde_a = (i < 2); dir_a = (i == 0) ? 4'd3 : 4'd15;
      tick();
      checks++;
      if (dout_a !== want_d[i] || val_a !== want_v[i] || dout_a !== m_dout[0] || val_a !== m_val[0]) begin
        errors++;
        $display("FAIL write_read step %0d: got dout=%h val=%b want %h %b", i, dout_a, val_a, want_d[i], want_v[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    wre_a = 1; rde_a = 1; dir_a = 4'd7; din_a = 8'h5A;
    tick();
    checks++;
    if (dout_a !== 8'h5A || val_a !== 1'b1) begin
      errors++;
      $display("FAIL write_first: got dout=%h val=%b want 5a 1", dout_a, val_a);
    end
    wre_a = 0; din_a = 8'h00;
    tick();
    checks++;
    if (dout_a !== 8'h5A || val_a !== 1'b1) begin
      errors++;
      $display("FAIL reread_7: got dout=%h val=%b want 5a 1", dout_a, val_a);
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    for (int a = 0; a < 16; a++) begin
      wre_a = 1; dir_a = 4'(a); din_a = 8'hFF;
      tick();
    end
    idle_inputs();
    clr_a = 1;
    tick();
    clr_a = 0;
    checks++;
    if (ocu_a !== 1'b1) begin
      errors++;
      $display("FAIL clr_entry: got ocu=%b want 1", ocu_a);
    end
    for (int i = 0; i < 16; i++) begin
      wre_a = (i == 5); rde_a = (i == 6); dir_a = 4'd0; din_a = 8'h11;
      tick();
      checks++;
      if (ocu_a !== logic'(i < 15) || val_a !== 1'b0) begin
        errors++;
        $display("FAIL clr_sweep edge %0d: got ocu=%b val=%b want ocu=%b val=0", i, ocu_a, val_a, i < 15);
      end
    end
    for (int i = 0; i < 2; i++) begin
      wre_a = 0; rde_a = 1; dir_a = (i == 0) ? 4'd0 : 4'd9;
      tick();
      checks++;
      if (dout_a !== 8'h00 || val_a !== 1'b1 || dout_a !== m_dout[0]) begin
        errors++;
        $display("FAIL cleared_read @%0d: got dout=%h val=%b want 00 1", dir_a, dout_a, val_a);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_sweep();
    wre_a = 1; dir_a = 4'd2; din_a = 8'h99; tick();
    wre_a = 0; rde_a = 1; tick();
    rde_a = 0;
    checks++;
    if (dout_a !== 8'h99) begin
      errors++;
      $display("FAIL pre_reset_read: got dout=%h want 99", dout_a);
    end
    clr_a = 1; tick();
    clr_a = 0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({dout_a, val_a, ocu_a, err_a} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_sweep_reset: got dout=%h val=%b ocu=%b err=%b want 00 0 1 0", dout_a, val_a, ocu_a, err_a);
    end
    #2 rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (ocu_a !== logic'(i < 15) || ocu_b !== logic'(i < 11)) begin
        errors++;
        $display("FAIL resweep edge %0d: got ocu_a=%b ocu_b=%b want %b %b", i, ocu_a, ocu_b, i < 15, i < 11);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wre_a = 1'($urandom); rde_a = 1'($urandom); clr_a = ($urandom_range(0, 39) == 0);
      dir_a = 4'($urandom); din_a = 8'($urandom);
      wre_b = 1'($urandom); rde_b = 1'($urandom); clr_b = ($urandom_range(0, 39) == 0);
      dir_b = 4'($urandom); din_b = 8'($urandom);
      tick();
      checks++;
      if ({dout_a, val_a, ocu_a, err_a} !== {m_dout[0], m_val[0], m_left[0] > 0, m_err[0]}) begin
        errors++;
        $display("FAIL random_a cycle %0d: got %h %b %b %b want %h %b %b %b", n, dout_a, val_a, ocu_a, err_a,
                 m_dout[0], m_val[0], m_left[0] > 0, m_err[0]);
      end
      checks++;
      if ({dout_b, val_b, ocu_b, err_b} !== {m_dout[1], m_val[1], m_left[1] > 0, m_err[1]}) begin
        errors++;
        $display("FAIL random_b cycle %0d: got %h %b %b %b want %h %b %b %b", n, dout_b, val_b, ocu_b, err_b,
                 m_dout[1], m_val[1], m_left[1] > 0, m_err[1]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    int budget;
    budget = 0;
    while (ocu_b !== 1'b0 && budget < 40) begin
      tick();
      budget++;
    end
    checks++;
    if (ocu_b !== 1'b0) begin
      errors++;
      $display("FAIL oor_wait_idle: got ocu=%b want 0 within 40 cycles", ocu_b);
    end
    wre_b = 1; dir_b = 4'd11; din_b = 8'h42; tick();
    wre_b = 1; dir_b = 4'd13; din_b = 8'h77; tick();
    checks++;
    if (err_b !== 1'b1 || val_b !== 1'b0) begin
      errors++;
      $display("FAIL oor_write: got err=%b val=%b want 1 0", err_b, val_b);
    end
    idle_inputs();
    tick();
    checks++;
    if (err_b !== 1'b0) begin
      errors++;
      $display("FAIL oor_err_pulse: got err=%b want 0", err_b);
    end
    rde_b = 1; dir_b = 4'd13; tick();
    checks++;
    if ({dout_b, val_b, err_b} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL oor_read: got dout=%h val=%b err=%b want 00 1 1", dout_b, val_b, err_b);
    end
    dir_b = 4'd11; tick();
    checks++;
    if ({dout_b, val_b, err_b} !== {8'h42, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL oor_read_11: got dout=%h val=%b err=%b want 42 1 0", dout_b, val_b, err_b);
    end
    for (int a = 0; a < 12; a++) begin
      dir_b = 4'(a); tick();
      checks++;
      if (dout_b !== m_dout[1] || val_b !== 1'b1 || err_b !== 1'b0) begin
        errors++;
        $display("FAIL oor_contents @%0d: got dout=%h val=%b err=%b want %h 1 0", a, dout_b, val_b, err_b, m_dout[1]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sweep_after_reset();
    test_write_read();
    test_same_cycle();
    test_clear();
    test_reset_mid_sweep();
    test_random();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
